// File: rtl/tx_sched_pkg.sv
// Shared types and helpers for the TX scheduling path.
package tx_sched_pkg;

  localparam int unsigned NUM_Q  = 4;
  localparam int unsigned QID_W  = 2;
  localparam int unsigned DESC_W = 64;

  typedef struct packed {
    logic             vld;
    logic [QID_W-1:0] idx;
  } qidx_t;

  // vld is set only for an exactly one-hot grant vector.
  function automatic qidx_t onehot4_to_idx(input logic [NUM_Q-1:0] oh);
    qidx_t r;
    r.vld = 1'b0;
    r.idx = '0;
    unique case (oh)
      4'b0001: begin r.vld = 1'b1; r.idx = 2'd0; end
      4'b0010: begin r.vld = 1'b1; r.idx = 2'd1; end
      4'b0100: begin r.vld = 1'b1; r.idx = 2'd2; end
      4'b1000: begin r.vld = 1'b1; r.idx = 2'd3; end
      default: begin r.vld = 1'b0; r.idx = '0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tx_qp_fifo.sv
// Single synchronous descriptor FIFO; storage is not reset, only pointers and count.
module tx_qp_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == FullCnt);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/tx_qp_desc_queue.sv
// Four per-class descriptor queues feeding the WRR arbiter, with a registered
// output stage and sticky illegal-grant detection.
module tx_qp_desc_queue
  import tx_sched_pkg::*;
#(
  parameter int unsigned DW    = DESC_W,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [QID_W-1:0]       in_qid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  output logic                   req0,
  output logic                   req1,
  output logic                   req2,
  output logic                   req3,
  output logic                   req_val,
  input  logic                   gnt0,
  input  logic                   gnt1,
  input  logic                   gnt2,
  input  logic                   gnt3,
  output logic                   gnt_busy,
  output logic                   out_valid,
  output logic [DW-1:0]          out_data,
  output logic [QID_W-1:0]       out_qid,
  input  logic                   out_ready,
  output logic [NUM_Q*(AW+1)-1:0] q_cnt,
  output logic                   err_gnt
);

  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]    w_cnt  [NUM_Q];
  logic [DW-1:0]    w_dout [NUM_Q];
  logic [NUM_Q-1:0] w_full;
  logic [NUM_Q-1:0] w_empty;
  logic [NUM_Q-1:0] w_push;
  logic [NUM_Q-1:0] w_pop;
  logic [NUM_Q-1:0] w_gnt;
  qidx_t            w_gidx;
  logic             w_legal;
  logic             w_err;

  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic [QID_W-1:0] r_out_qid;
  logic             r_err;

  // in_ready deliberately ignores any same-cycle pop so gnt never reaches it.
  assign in_ready = ~w_full[in_qid];

  for (genvar g = 0; g < NUM_Q; g++) begin : g_q
    assign w_push[g]           = in_valid & in_ready & (in_qid == QID_W'(g));
    assign w_pop[g]            = w_legal & (w_gidx.idx == QID_W'(g));
    assign q_cnt[g*CW +: CW]   = w_cnt[g];

    tx_qp_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_din   (in_data),
      .o_dout  (w_dout[g]),
      .o_count (w_cnt[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  assign req0    = ~w_empty[0];
  assign req1    = ~w_empty[1];
  assign req2    = ~w_empty[2];
  assign req3    = ~w_empty[3];
  assign req_val = |(~w_empty);

  assign gnt_busy = r_out_valid & ~out_ready;

  assign w_gnt   = {gnt3, gnt2, gnt1, gnt0};
  assign w_gidx  = onehot4_to_idx(w_gnt);
  assign w_legal = w_gidx.vld & ~w_empty[w_gidx.idx] & ~gnt_busy;
  // Covers multi-hot, empty-target and grant-while-busy in one term.
  assign w_err   = (w_gnt != '0) & ~w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_qid   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_legal) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_dout[w_gidx.idx];
        r_out_qid   <= w_gidx.idx;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_err) r_err <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_qid   = r_out_qid;
  assign err_gnt   = r_err;

endmodule

// File: tb/tb_tx_qp_desc_queue.sv
// Directed bench for tx_qp_desc_queue with a per-queue reference model and output scoreboard.
module tb_tx_qp_desc_queue;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [1:0]     in_qid;
  logic [DW-1:0]  in_data;
  logic           in_ready;
  logic           req0, req1, req2, req3, req_val;
  logic [3:0]     gnt;
  logic           gnt_busy;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [1:0]     out_qid;
  logic           out_ready;
  logic [4*CW-1:0] q_cnt;
  logic           err_gnt;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mq [4][$];
  logic [65:0] sb [$];
  logic        mv;
  logic        merr;
  int          rr = 0;

  always #5 clk = ~clk;

  tx_qp_desc_queue #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_qid    (in_qid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req0      (req0),
    .req1      (req1),
    .req2      (req2),
    .req3      (req3),
    .req_val   (req_val),
    .gnt0      (gnt[0]),
    .gnt1      (gnt[1]),
    .gnt2      (gnt[2]),
    .gnt3      (gnt[3]),
    .gnt_busy  (gnt_busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_qid   (out_qid),
    .out_ready (out_ready),
    .q_cnt     (q_cnt),
    .err_gnt   (err_gnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [3:0] reqs;
    reqs = {req3, req2, req1, req0};
    chk("out_valid", out_valid, mv);
    if (mv) begin
      chk("out_data", out_data, sb[0][63:0]);
      chk("out_qid", out_qid, sb[0][65:64]);
    end
    for (int q = 0; q < 4; q++) begin
      chk($sformatf("q_cnt%0d", q), q_cnt[q*CW +: CW], mq[q].size());
      chk($sformatf("req%0d", q), reqs[q], mq[q].size() != 0);
    end
    chk("req_val", req_val, (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0);
    chk("err_gnt", err_gnt, merr);
  endtask

  // One clock: predict the edge from the model, advance, then compare.
  task automatic tick();
    int   idx;
    logic oh, legal, xfer, acc;
    idx = 0;
    for (int k = 0; k < 4; k++) if (gnt[k]) idx = k;
    oh    = $onehot(gnt);
    xfer  = mv && out_ready;
    legal = oh && (mq[idx].size() > 0) && !(mv && !out_ready);
    acc   = in_valid && (mq[in_qid].size() < DEPTH);
    @(posedge clk);
    #1;
    if (xfer) void'(sb.pop_front());
    if (legal) sb.push_back({idx[1:0], mq[idx].pop_front()});
    mv = legal ? 1'b1 : (out_ready ? 1'b0 : mv);
    if (gnt != 4'b0 && !legal) merr = 1'b1;
    if (acc) mq[in_qid].push_back(in_data);
    check_state();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    gnt      = 4'b0;
    rst_n    = 1'b0;
    #1;
    for (int q = 0; q < 4; q++) mq[q].delete();
    sb.delete();
    mv   = 1'b0;
    merr = 1'b0;
    check_state();
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_qid", out_qid, 2'd0);
    @(posedge clk);
    #1;
    check_state();
    rst_n = 1'b1;
  endtask

  task automatic pick_grant();
    gnt = 4'b0;
    if (!(mv && !out_ready)) begin
      for (int k = 0; k < 4; k++) begin
        int q;
        q = (rr + k) % 4;
        if (gnt == 4'b0 && mq[q].size() != 0) gnt[q] = 1'b1;
      end
      rr = (rr + 1) % 4;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_qid    = 2'd0;
    in_data   = '0;
    gnt       = 4'b0;
    out_ready = 1'b1;
    mv        = 1'b0;
    merr      = 1'b0;
    #2;
    do_reset();

    // Reset mid-traffic: 3 entries left in q2 and a stalled output.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_qid    = 2'd2;
    for (int i = 0; i < 4; i++) begin
      in_data = 64'h200 + 64'(i);
      tick();
    end
    in_valid = 1'b0;
    gnt      = 4'b0100;
    tick();
    gnt = 4'b0;
    chk("pre_rst_cnt2", q_cnt[2*CW +: CW], 4'd3);
    chk("pre_rst_valid", out_valid, 1'b1);
    do_reset();
    out_ready = 1'b1;

    // Latency: push at t, req at t+1, output at t+2.
    in_valid = 1'b1;
    in_qid   = 2'd1;
    in_data  = 64'hA5;
    #1;
    chk("no_bypass_req1", req1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("lat_req1", req1, 1'b1);
    gnt = 4'b0010;
    tick();
    gnt = 4'b0;
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_data", out_data, 64'hA5);
    chk("lat_qid", out_qid, 2'd1);
    chk("lat_cnt1", q_cnt[1*CW +: CW], 4'd0);
    tick();

    // Full queue and blocked ninth push.
    in_valid = 1'b1;
    in_qid   = 2'd3;
    for (int i = 0; i < 8; i++) begin
      in_data = 64'h300 + 64'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("full_ready_q3", in_ready, 1'b0);
    in_qid = 2'd0;
    #1;
    chk("full_ready_q0", in_ready, 1'b1);
    in_qid   = 2'd3;
    in_valid = 1'b1;
    in_data  = 64'hDEAD;
    tick();
    in_valid = 1'b0;
    chk("full_cnt3", q_cnt[3*CW +: CW], 4'd8);

    // Backpressure: stall, hold, then release with a same-cycle grant.
    out_ready = 1'b0;
    gnt       = 4'b1000;
    tick();
    gnt = 4'b0;
    #1;
    chk("bp_busy", gnt_busy, 1'b1);
    tick();
    chk("bp_hold", out_data, 64'h300);
    out_ready = 1'b1;
    #1;
    chk("bp_unbusy", gnt_busy, 1'b0);
    gnt = 4'b1000;
    tick();
    gnt = 4'b0;
    chk("bp_next", out_data, 64'h301);
    tick();

    // Simultaneous push and pop on q0 holding 4 entries.
    in_valid = 1'b1;
    in_qid   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_data = 64'h10 + 64'(i);
      tick();
    end
    in_data = 64'h14;
    gnt     = 4'b0001;
    tick();
    in_valid = 1'b0;
    chk("simul_cnt0", q_cnt[0*CW +: CW], 4'd4);
    for (int i = 0; i < 4; i++) tick();
    gnt = 4'b0;
    tick();

    // Mixed random traffic; wraps pointers and exercises intermittent stalls.
    for (int i = 0; i < 40; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_qid    = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom};
      out_ready = $urandom_range(0, 3) != 0;
      pick_grant();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0 || mv) begin
        pick_grant();
        tick();
      end
    end
    gnt = 4'b0;
    chk("drain_empty", req_val, 1'b0);

    // Illegal grants: multi-hot, then an empty target; err stays sticky.
    in_valid = 1'b1;
    in_qid   = 2'd1;
    in_data  = 64'hBEEF;
    tick();
    in_valid = 1'b0;
    tick();
    gnt = 4'b0110;
    tick();
    gnt = 4'b0;
    chk("ill_mh_err", err_gnt, 1'b1);
    chk("ill_mh_cnt1", q_cnt[1*CW +: CW], 4'd1);
    gnt = 4'b0100;
    tick();
    gnt = 4'b0;
    chk("ill_empty_cnt2", q_cnt[2*CW +: CW], 4'd0);
    tick();
    tick();
    chk("ill_sticky", err_gnt, 1'b1);
    do_reset();
    chk("ill_cleared", err_gnt, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_qp_desc_queue.md
Name: tx_qp_desc_queue

Overview:
- Upstream feeder for the 4-way WRR TX arbiter.
- Buffers TX work descriptors in four per-QP-class FIFOs.
- Presents one request per non-empty queue (req0..req3) to the arbiter and consumes its one-hot grant by popping the granted queue's head into a registered output stage.
- Drives gnt_busy back to the arbiter so grants are frozen while the output stage is stalled by the downstream TX engine.

Parameters:
- DW, 64, descriptor payload width in bits
- DEPTH, 8, entries per queue; power of 2, minimum 2
- AW, log2(DEPTH), pointer width (derived, localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  descriptor enqueue request
- in_qid  in  2  target queue 0..3
- in_data  in  DW  descriptor payload
- in_ready  out  1  target queue (in_qid) not full; combinational from in_qid and registered counts
- req0..req3  out  1 each  queue i non-empty (registered count != 0)
- req_val  out  1  OR of req0..req3
- gnt0..gnt3  in  1 each  one-hot grant from arbiter (already masked by gnt_busy)
- gnt_busy  out  1  out_valid & ~out_ready
- out_valid  out  1  output descriptor valid
- out_data  out  DW  output descriptor
- out_qid  out  2  source queue of out_data
- out_ready  in  1  downstream accepts
- q_cnt  out  4*(AW+1)  per-queue occupancy; queue i at bits [i*(AW+1) +: AW+1]
- err_gnt  out  1  sticky illegal-grant flag

Behaviour:
- Reset (rst_n low, async): all counts and pointers 0, req*=0, req_val=0, out_valid=0, out_data=0, out_qid=0, err_gnt=0. FIFO storage is not reset. Reset mid-operation discards all queued and output data.
- Enqueue: push when in_valid & in_ready. in_ready = count[in_qid] != DEPTH. No credit is given for a same-cycle pop, so there is no combinational path from gnt to in_ready.
- req_i is driven only from the registered count (no push bypass).
  - Data enqueued in cycle t raises req_i in t+1.
  - Earliest grant is t+1; out_valid is high in t+2.
- Legal grant: gnt is exactly one-hot, the granted queue has count != 0, and gnt_busy=0.
  - Action: pop the head; out_data <= head; out_qid <= index; out_valid <= 1.
- Illegal grant: gnt nonzero and either not one-hot or targeting an empty queue.
  - No pop; err_gnt <= 1 (sticky until reset); the output stage follows the no-grant rule.
- gnt nonzero while gnt_busy=1 (arbiter violation): ignored, err_gnt <= 1.
- No grant: if out_ready, out_valid <= 0; otherwise hold out_valid, out_data, out_qid.
- Throughput: one descriptor per cycle with out_ready held high; pop and drain occur in the same cycle.
- Same-queue push and pop in one cycle: count unchanged, both pointers advance.
  - Full queue: push is blocked by in_ready; the pop proceeds.
  - Empty queue: req=0, so no pop; the push is visible next cycle.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH in AW+1 bits.
- Ordering: FIFO order within each queue; ordering across queues is set by the arbiter.
- gnt_busy is combinational from out_valid (registered) and out_ready. There is no loop because gnt does not feed gnt_busy.

Decomposition:
- Package tx_sched_pkg: NUM_Q=4, QID_W=2, descriptor width default, and a function onehot4_to_idx returning index plus a valid flag.
- Sub-module tx_qp_fifo: a single synchronous FIFO (push, pop, dout, count, full, empty). Instantiate it four times.
- Top level holds the grant decode, the output register and the error logic.

Test Plan:
- Reset: hold rst_n low mid-traffic with 3 entries in q2 -> all req*=0, q_cnt=0, out_valid=0, err_gnt=0 on the next edge.
- Latency: enqueue 0xA5 to q1 at t, grant gnt1 in t+1 -> req1=1 at t+1; out_valid=1, out_data=0xA5, out_qid=1 at t+2; q_cnt[1]=0.
- Full: push 8 entries to q3 with no grant -> q_cnt[3]=8, in_ready=0 for in_qid=3 and 1 for in_qid=0; 9th push is not accepted.
- Backpressure: out_valid=1 and out_ready=0 -> gnt_busy=1; raise out_ready -> gnt_busy=0; a grant the same cycle pops the next entry, with no loss and no duplication.
- Simultaneous: q0 count=4, push to q0 and gnt0 in the same cycle -> count stays 4; output order matches enqueue order.
- Illegal grant: gnt=4'b0110, or gnt2 with q2 empty -> no pop, counts unchanged, err_gnt=1 and held until reset.
